mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the core's single data-memory port between the instruction fetch unit (IFU) and the load/store path of the memory stage (LSU). It sits between the pipeline's valid/ready stage buses and the memory model, allows one outstanding transaction at a time and routes each response back to the requester that issued it. LSU has fixed priority, with a starvation guard that forces an IFU grant after a configurable number of consecutive contested LSU grants.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the IFU and the LSU. One transaction is outstanding at a time.
// LSU has fixed priority, and a streak counter forces an IFU grant after STARVE_LIMIT contested LSU wins.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    state_e      state_q;
    logic        owner_q;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [7:0]  wmask_q;
    logic [31:0] rdata_q;
    logic [7:0]  streak_q;
    logic [7:0]  streak_d;
    logic        mem_req_valid_q;
    logic        mem_resp_ready_q;
    logic        ifu_resp_valid_q;
    logic        lsu_resp_valid_q;
    logic        starve_s;
    logic        lsu_win_s;
    logic        ifu_win_s;

    // Arbitration in IDLE and the next value of the streak counter
    always_comb begin
        starve_s  = ifu_req_valid && (LIMIT_C != 8'd0) && (streak_q >= LIMIT_C);
        lsu_win_s = (state_q == IDLE) && lsu_req_valid && !starve_s;
        ifu_win_s = (state_q == IDLE) && ifu_req_valid && !lsu_win_s;
        streak_d  = streak_q;
        if (ifu_win_s) begin
            streak_d = 8'd0;
        end else if (lsu_win_s && ifu_req_valid && (streak_q != 8'hFF)) begin
            streak_d = streak_q + 8'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // Transaction FSM with request latch, response buffer and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= 1'b0;
            addr_q           <= 32'd0;
            wen_q            <= 1'b0;
            wdata_q          <= 32'd0;
            wmask_q          <= 8'd0;
            rdata_q          <= 32'd0;
            streak_q         <= 8'd0;
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    if (lsu_win_s) begin
                        owner_q         <= 1'b1;
                        addr_q          <= lsu_addr;
                        wen_q           <= lsu_wen;
                        wdata_q         <= lsu_wdata;
                        wmask_q         <= lsu_wmask;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end else if (ifu_win_s) begin
                        owner_q         <= 1'b0;
                        addr_q          <= ifu_addr;
                        wen_q           <= 1'b0;
                        wdata_q         <= 32'd0;
                        wmask_q         <= 8'd0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q  <= 1'b0;
                        mem_resp_ready_q <= 1'b1;
                        state_q          <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q          <= mem_rdata;
                        mem_resp_ready_q <= 1'b0;
                        ifu_resp_valid_q <= !owner_q;
                        lsu_resp_valid_q <= owner_q;
                        state_q          <= RESP;
                    end
                end
                RESP: begin
                    // Only the owner's resp_ready can close the transaction
                    if (owner_q ? lsu_resp_ready : ifu_resp_ready) begin
                        ifu_resp_valid_q <= 1'b0;
                        lsu_resp_valid_q <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: begin
                    mem_req_valid_q  <= 1'b0;
                    mem_resp_ready_q <= 1'b0;
                    ifu_resp_valid_q <= 1'b0;
                    lsu_resp_valid_q <= 1'b0;
                    state_q          <= IDLE;
                end
            endcase
        end
    end

    assign ifu_req_ready  = ifu_win_s;
    assign lsu_req_ready  = lsu_win_s;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_resp_ready = mem_resp_ready_q;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// A second instance with STARVE_LIMIT=0 shares the inputs and is checked for pure LSU priority.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_wen, lsu_resp_ready;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [7:0]  lsu_wmask;

    logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
    logic        mem_req_valid, mem_wen, mem_resp_ready;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;

    logic        ifu_req_ready_z, ifu_resp_valid_z, lsu_req_ready_z, lsu_resp_valid_z;
    logic        mem_req_valid_z, mem_wen_z, mem_resp_ready_z;
    logic [31:0] ifu_rdata_z, lsu_rdata_z, mem_addr_z, mem_wdata_z;
    logic [7:0]  mem_wmask_z;

    int tests_run = 0;
    int tests_failed = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_z), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_z), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata_z),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_z), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_z), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata_z),
        .mem_req_valid(mem_req_valid_z), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_z),
        .mem_wen(mem_wen_z), .mem_wdata(mem_wdata_z), .mem_wmask(mem_wmask_z),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready_z), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifu_req_valid = 1'b0; ifu_resp_ready = 1'b0; ifu_addr = 32'd0;
        lsu_req_valid = 1'b0; lsu_resp_ready = 1'b0; lsu_addr = 32'd0;
        lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 8'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Zero-wait memory: called in the REQ cycle, returns in the RESP cycle
    task automatic serve_mem(input logic [31:0] d);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = d;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready, mem_wen} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b exp=0", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready, mem_wen});
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== 136'd0) begin
            tests_failed++;
            $display("FAIL reset_data got addr=%h wdata=%h wmask=%h ird=%h lrd=%h exp=0", mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
        end
        tests_run++;
        if (dut.streak_q !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_streak got=%0d exp=0", dut.streak_q);
        end
    endtask

    task automatic test_ifu_read;
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000;
        #1;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL ifu_accept got=%b exp=10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr = 32'h1234_5678;
        mem_req_ready = 1'b1;
        #1;
        tests_run++;
        if ({mem_req_valid, mem_wen, mem_wmask, mem_addr} !== {1'b1, 1'b0, 8'h00, 32'h8000_0000}) begin
            tests_failed++;
            $display("FAIL ifu_memreq got v=%b wen=%b mask=%h addr=%h exp v=1 wen=0 mask=00 addr=80000000", mem_req_valid, mem_wen, mem_wmask, mem_addr);
        end
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0413;
        #1;
        tests_run++;
        if (mem_resp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ifu_wait got mem_resp_ready=%b exp=1", mem_resp_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        ifu_resp_ready = 1'b1;
        #1;
        tests_run++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {1'b1, 1'b0, 32'h0000_0413}) begin
            tests_failed++;
            $display("FAIL ifu_resp got iv=%b lv=%b rdata=%h exp iv=1 lv=0 rdata=00000413", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
        end
        tick();
        ifu_resp_ready = 1'b0;
        tests_run++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ifu_done got=%b exp=000", {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
        end
    endtask

    task automatic test_store;
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_wen = 1'b1;
        lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 8'h0F;
        #1;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL store_accept got=%b exp=01", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        lsu_req_valid = 1'b0;
        lsu_wen = 1'b0;
        lsu_addr = 32'd0;
        lsu_wdata = 32'd0;
        lsu_wmask = 8'd0;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready = (c == 3) ? 1'b1 : 1'b0;
            #1;
            tests_run++;
            if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 8'h0F}) begin
                tests_failed++;
                $display("FAIL store_hold c=%0d got v=%b wen=%b addr=%h wdata=%h mask=%h", c, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        tests_run++;
        if ({mem_req_valid, mem_resp_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL store_wait got=%b exp=01", {mem_req_valid, mem_resp_ready});
        end
        tick();
        mem_resp_valid = 1'b0;
        lsu_resp_ready = 1'b1;
        #1;
        tests_run++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01) begin
            tests_failed++;
            $display("FAIL store_ack got=%b exp=01", {ifu_resp_valid, lsu_resp_valid});
        end
        tick();
        lsu_resp_ready = 1'b0;
        tests_run++;
        if (lsu_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_done got=%b exp=0", lsu_resp_valid);
        end
    endtask

    task automatic test_contention;
        int m;
        logic exp_lsu;
        do_reset();
        m = 0;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int g = 0; g < 12; g++) begin
            ifu_addr = $urandom;
            lsu_addr = $urandom;
            #1;
            exp_lsu = !(m >= LIMIT);
            tests_run++;
            if ({ifu_req_ready, lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
                tests_failed++;
                $display("FAIL contend_grant g=%0d got=%b exp=%b", g, {ifu_req_ready, lsu_req_ready}, {!exp_lsu, exp_lsu});
            end
            m = exp_lsu ? ((m < 255) ? m + 1 : 255) : 0;
            tick();
            if (!exp_lsu) begin
                tests_run++;
                if (dut.streak_q !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL contend_streak g=%0d got=%0d exp=0", g, dut.streak_q);
                end
            end
            serve_mem($urandom);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starve0;
        int mz;
        do_reset();
        mz = 0;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int g = 0; g < 260; g++) begin
            #1;
            tests_run++;
            if ({ifu_req_ready_z, lsu_req_ready_z} !== 2'b01) begin
                tests_failed++;
                $display("FAIL starve0_grant g=%0d got=%b exp=01", g, {ifu_req_ready_z, lsu_req_ready_z});
            end
            mz = (mz < 255) ? mz + 1 : 255;
            tick();
            tests_run++;
            if (dut0.streak_q !== 8'(mz)) begin
                tests_failed++;
                $display("FAIL starve0_streak g=%0d got=%0d exp=%0d", g, dut0.streak_q, mz);
            end
            serve_mem($urandom);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_resp_backpressure;
        logic [31:0] d;
        logic [1:0]  exp_rv;
        for (int own = 0; own < 2; own++) begin
            do_reset();
            d = $urandom;
            exp_rv = (own == 1) ? 2'b01 : 2'b10;
            if (own == 1) begin
                lsu_req_valid = 1'b1; lsu_addr = $urandom; lsu_wen = 1'b0;
            end else begin
                ifu_req_valid = 1'b1; ifu_addr = $urandom;
            end
            #1;
            tick();
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            serve_mem(d);
            ifu_resp_ready = (own == 1) ? 1'b1 : 1'b0;
            lsu_resp_ready = (own == 1) ? 1'b0 : 1'b1;
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            for (int c = 0; c < 5; c++) begin
                mem_rdata = $urandom;
                #1;
                tests_run++;
                if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata, ifu_req_ready, lsu_req_ready} !== {exp_rv, d, d, 2'b00}) begin
                    tests_failed++;
                    $display("FAIL bp_hold own=%0d c=%0d got rv=%b ird=%h lrd=%h rdy=%b exp rv=%b rd=%h rdy=00",
                             own, c, {ifu_resp_valid, lsu_resp_valid}, ifu_rdata, lsu_rdata, {ifu_req_ready, lsu_req_ready}, exp_rv, d);
                end
                tick();
            end
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            ifu_resp_ready = 1'b1;
            lsu_resp_ready = 1'b1;
            #1;
            tick();
            tests_run++;
            if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL bp_release own=%0d got=%b exp=00", own, {ifu_resp_valid, lsu_resp_valid});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait;
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr = $urandom | 32'h0000_0004;
        #1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        tests_run++;
        if (mem_resp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstwait_pre got mem_resp_ready=%b exp=1", mem_resp_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready, mem_wen, mem_addr} !== 39'd0) begin
            tests_failed++;
            $display("FAIL rstwait_clear got ctrl=%b addr=%h exp 0",
                     {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready, mem_wen}, mem_addr);
        end
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        ifu_resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests_run++;
            if ({mem_resp_ready, ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {3'b000, 32'd0}) begin
                tests_failed++;
                $display("FAIL rstwait_ignore c=%0d got mrr=%b rv=%b rd=%h exp 0", c, mem_resp_ready, {ifu_resp_valid, lsu_resp_valid}, ifu_rdata);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random(input int n);
        int          m;
        logic        busy, own, req_done, resp_got, lw, iw, g_ifu, g_lsu;
        logic [31:0] r_addr, r_wdata, r_rd;
        logic        r_wen;
        logic [7:0]  r_wmask;
        logic        e_mrv, e_mrr;
        logic [1:0]  e_rv;
        do_reset();
        m = 0; busy = 1'b0; own = 1'b0; req_done = 1'b0; resp_got = 1'b0;
        r_addr = 32'd0; r_wdata = 32'd0; r_rd = 32'd0; r_wen = 1'b0; r_wmask = 8'd0;
        for (int cyc = 0; cyc < n; cyc++) begin
            if (!ifu_req_valid && ($urandom_range(2) == 0)) begin
                ifu_req_valid = 1'b1; ifu_addr = $urandom;
            end
            if (!lsu_req_valid && ($urandom_range(2) == 0)) begin
                lsu_req_valid = 1'b1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
                lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
            end
            mem_req_ready = 1'($urandom); mem_resp_valid = 1'($urandom); mem_rdata = $urandom;
            ifu_resp_ready = 1'($urandom); lsu_resp_ready = 1'($urandom);
            #1;
            e_mrv = busy && !req_done;
            e_mrr = busy && req_done && !resp_got;
            e_rv  = (busy && resp_got) ? (own ? 2'b01 : 2'b10) : 2'b00;
            tests_run++;
            if ({mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid} !== {e_mrv, e_mrr, e_rv}) begin
                tests_failed++;
                $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}, {e_mrv, e_mrr, e_rv});
            end
            if (e_mrv) begin
                tests_run++;
                if ({mem_addr, mem_wen, mem_wmask} !== {r_addr, r_wen, r_wmask} || (r_wen && (mem_wdata !== r_wdata))) begin
                    tests_failed++;
                    $display("FAIL rnd_fields cyc=%0d got %h/%b/%h/%h exp %h/%b/%h/%h", cyc, mem_addr, mem_wen, mem_wmask, mem_wdata, r_addr, r_wen, r_wmask, r_wdata);
                end
            end
            if (busy && resp_got) begin
                tests_run++;
                if ({ifu_rdata, lsu_rdata} !== {r_rd, r_rd}) begin
                    tests_failed++;
                    $display("FAIL rnd_rdata cyc=%0d got %h/%h exp %h", cyc, ifu_rdata, lsu_rdata, r_rd);
                end
            end
            g_ifu = 1'b0;
            g_lsu = 1'b0;
            if (!busy) begin
                lw = lsu_req_valid && !(ifu_req_valid && (m >= LIMIT));
                iw = ifu_req_valid && !lw;
                tests_run++;
                if ({ifu_req_ready, lsu_req_ready} !== {iw, lw}) begin
                    tests_failed++;
                    $display("FAIL rnd_grant cyc=%0d got=%b exp=%b streak=%0d", cyc, {ifu_req_ready, lsu_req_ready}, {iw, lw}, m);
                end
                if (lw) begin
                    busy = 1'b1; own = 1'b1; req_done = 1'b0; resp_got = 1'b0; g_lsu = 1'b1;
                    r_addr = lsu_addr; r_wen = lsu_wen; r_wdata = lsu_wdata; r_wmask = lsu_wmask;
                    if (ifu_req_valid) m = (m < 255) ? m + 1 : 255;
                end else if (iw) begin
                    busy = 1'b1; own = 1'b0; req_done = 1'b0; resp_got = 1'b0; g_ifu = 1'b1;
                    r_addr = ifu_addr; r_wen = 1'b0; r_wdata = 32'd0; r_wmask = 8'd0;
                    m = 0;
                end
            end else begin
                tests_run++;
                if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL rnd_busy_rdy cyc=%0d got=%b exp=00", cyc, {ifu_req_ready, lsu_req_ready});
                end
                if (e_mrv && mem_req_ready) begin
                    req_done = 1'b1;
                end else if (e_mrr && mem_resp_valid) begin
                    resp_got = 1'b1; r_rd = mem_rdata;
                end else if (resp_got && (own ? lsu_resp_ready : ifu_resp_ready)) begin
                    busy = 1'b0;
                end
            end
            tick();
            if (g_ifu) ifu_req_valid = 1'b0;
            if (g_lsu) lsu_req_valid = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_ifu_read();
        test_store();
        test_contention();
        test_starve0();
        test_resp_backpressure();
        test_reset_in_wait();
        test_random(3000);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
